// File: rtl/uart_tx_sched_if.sv
// Bus between byte sources / serializer and the uart_tx_sched scheduler.
//
// Handshake rule: a requester raises req_valid[i] with its byte on
// req_data[8i+7:8i] and holds both stable until it sees req_ready[i]=1 for
// one cycle; that cycle is the transfer. Valid dropped before the grant edge
// means no transfer.
//
// Signals:
//   req_valid  client -> sched   per-requester byte valid
//   req_data   client -> sched   byte for requester i at [8i+7:8i]
//   req_ready  sched  -> client  one-hot accept pulse
//   start_tx   sched  -> ser     one-cycle launch pulse
//   data_tx    sched  -> ser     byte to send, held until frame end
//   done_tx    ser    -> sched   frame-complete pulse
//   busy       sched  -> any     high whenever the scheduler is not idle
//   grant_id   sched  -> any     index of the requester last granted
//   wdog_err   sched  -> any     sticky: a frame was ended by the watchdog
//   clr_err    any    -> sched   synchronous clear of wdog_err
//   dbg_state  sched  -> any     current FSM state for observation
// Modports: master (client/serializer side), slave (scheduler).
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 start_tx;
    logic [7:0]           data_tx;
    logic                 done_tx;
    logic                 busy;
    logic [ID_W-1:0]      grant_id;
    logic                 wdog_err;
    logic                 clr_err;
    logic [1:0]           dbg_state;

    modport master (
        output req_valid, req_data, done_tx, clr_err,
        input  req_ready, start_tx, data_tx, busy, grant_id, wdog_err, dbg_state
    );

    modport slave (
        input  req_valid, req_data, done_tx, clr_err,
        output req_ready, start_tx, data_tx, busy, grant_id, wdog_err, dbg_state
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// sources. Accepts one byte per frame, launches the serializer with a
// one-cycle start pulse, waits for frame completion (or a watchdog timeout),
// optionally idles GAP_CYC cycles, then re-arbitrates.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    uart_tx_sched_if.slave (requests, serializer link, status)
module uart_tx_sched #(
    parameter int NUM_REQ  = 4,
    parameter int SYS_CLK  = 50_000_000,
    parameter int BPS      = 9600,
    parameter int WDOG_CYC = (SYS_CLK / BPS) * 11,
    parameter int GAP_CYC  = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_sched_if.slave bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(WDOG_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 2);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WDOG_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    logic [1:0]         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [WD_W-1:0]    wd_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W-1:0]    cand;
    logic [NUM_REQ-1:0] win_vec;
    logic               wd_hit;
    logic               wd_set;

    // Scan from the highest offset down so the lowest offset from rr_ptr
    // (the first set bit at or after the pointer, with wrap) is written last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        win_vec   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_vec[win_idx] = win_found;
    end

    assign wd_hit = (wd_cnt == WD_LAST);
    // done_tx on the final watchdog cycle is a normal completion.
    assign wd_set = (state == S_WAIT) && wd_hit && !bus.done_tx;

    assign bus.busy      = (state != S_IDLE);
    assign bus.dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            wd_cnt        <= '0;
            gap_cnt       <= '0;
            bus.req_ready <= '0;
            bus.start_tx  <= 1'b0;
            bus.data_tx   <= '0;
            bus.grant_id  <= '0;
            bus.wdog_err  <= 1'b0;
        end else begin
            bus.req_ready <= '0;
            bus.start_tx  <= 1'b0;

            // A timeout in the same cycle as a clear leaves the error set.
            if (wd_set) begin
                bus.wdog_err <= 1'b1;
            end else if (bus.clr_err) begin
                bus.wdog_err <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        state         <= S_LAUNCH;
                        bus.req_ready <= win_vec;
                        bus.start_tx  <= 1'b1;
                        bus.data_tx   <= bus.req_data[{win_idx, 3'b000} +: 8];
                        bus.grant_id  <= win_idx;
                        rr_ptr        <= (win_idx == ID_LAST) ? '0 : win_idx + 1'b1;
                    end
                end
                S_LAUNCH: begin
                    state  <= S_WAIT;
                    wd_cnt <= '0;
                end
                S_WAIT: begin
                    if (bus.done_tx || wd_hit) begin
                        state   <= (GAP_CYC == 0) ? S_IDLE : S_GAP;
                        gap_cnt <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;
    localparam int N    = 4;
    localparam int WDOG = 64;
    localparam int GAP  = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_sched_if #(.NUM_REQ(N)) bus0 ();
    uart_tx_sched_if #(.NUM_REQ(N)) bus1 ();

    uart_tx_sched #(.NUM_REQ(N), .WDOG_CYC(WDOG), .GAP_CYC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    uart_tx_sched #(.NUM_REQ(N), .GAP_CYC(GAP)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    int errors = 0;
    int checks = 0;
    int model_ptr;
    logic model_err;
    logic [7:0] exp_q[$];

    // Reference arbitration: first pending requester at or after ptr, wrapping.
    function automatic int rr_pick(input logic [N-1:0] pend, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // ---------------- clock / reset / drivers ----------------
    task automatic init_inputs();
        bus0.req_valid = '0; bus0.req_data = '0; bus0.done_tx = 1'b0; bus0.clr_err = 1'b0;
        bus1.req_valid = '0; bus1.req_data = '0; bus1.done_tx = 1'b0; bus1.clr_err = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        model_err = 1'b0;
    endtask

    task automatic set_lane0(input int i, input logic [7:0] d);
        bus0.req_data[i*8 +: 8] = d;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus0.busy); end
        checks++; if (bus0.start_tx !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", bus0.start_tx); end
        checks++; if (bus0.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", bus0.req_ready); end
        checks++; if (bus0.data_tx !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus0.data_tx); end
        checks++; if (bus0.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", bus0.grant_id); end
        checks++; if (bus0.wdog_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus0.wdog_err); end
        checks++; if (bus0.dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus0.dbg_state); end
        checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b expected 0", bus1.busy); end
        apply_reset();
    endtask

    task automatic test_single();
        for (int i = 0; i < N; i++) set_lane0(i, 8'($urandom_range(0, 255)));
        set_lane0(2, 8'hA5);
        bus0.req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (bus0.start_tx !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", bus0.start_tx); end
        checks++; if (bus0.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", bus0.req_ready); end
        checks++; if (bus0.data_tx !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", bus0.data_tx); end
        checks++; if (bus0.grant_id !== 2'd2) begin errors++; $display("FAIL single_grant: got %0d expected 2", bus0.grant_id); end
        bus0.req_valid = 4'b0000;
        bus0.req_data = 32'($urandom);
        @(negedge clk);
        checks++; if (bus0.start_tx !== 1'b0 || bus0.req_ready !== 4'b0000) begin
            errors++; $display("FAIL single_pulse_width: got start=%b ready=%b expected 0/0000", bus0.start_tx, bus0.req_ready);
        end
        checks++; if (bus0.busy !== 1'b1) begin errors++; $display("FAIL single_busy_wait: got %b expected 1", bus0.busy); end
        repeat (39) @(negedge clk);
        checks++; if (bus0.busy !== 1'b1) begin errors++; $display("FAIL single_busy_before_done: got %b expected 1", bus0.busy); end
        bus0.done_tx = 1'b1;
        @(negedge clk);
        bus0.done_tx = 1'b0;
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after_done: got %b expected 0", bus0.busy); end
        checks++; if (bus0.data_tx !== 8'hA5) begin errors++; $display("FAIL single_data_hold: got %h expected a5", bus0.data_tx); end
        checks++; if (bus0.wdog_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", bus0.wdog_err); end
        model_ptr = 3;
    endtask

    task automatic test_round_robin();
        logic [7:0] lane[N];
        logic [3:0] exp_ready;
        apply_reset();
        for (int i = 0; i < N; i++) begin
            lane[i] = 8'($urandom_range(0, 255));
            set_lane0(i, lane[i]);
        end
        bus0.req_valid = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            @(negedge clk);
            exp_ready = 4'b0001 << (f % N);
            checks++; if (bus0.start_tx !== 1'b1 || bus0.req_ready !== exp_ready) begin
                errors++; $display("FAIL rr_grant%0d: got start=%b ready=%b expected 1/%b", f, bus0.start_tx, bus0.req_ready, exp_ready);
            end
            checks++; if (bus0.grant_id !== 2'(f % N) || bus0.data_tx !== lane[f % N]) begin
                errors++; $display("FAIL rr_id_data%0d: got id=%0d data=%h expected %0d/%h", f, bus0.grant_id, bus0.data_tx, f % N, lane[f % N]);
            end
            lane[f % N] = 8'($urandom_range(0, 255));
            set_lane0(f % N, lane[f % N]);
            @(negedge clk);
            checks++; if (bus0.start_tx !== 1'b0 || bus0.req_ready !== 4'b0000) begin
                errors++; $display("FAIL rr_no_double%0d: got start=%b ready=%b expected 0/0000", f, bus0.start_tx, bus0.req_ready);
            end
            repeat (4) @(negedge clk);
            bus0.done_tx = 1'b1;
            @(negedge clk);
            bus0.done_tx = 1'b0;
            if (f == 4) bus0.req_valid = 4'b0000;
        end
        model_ptr = 1;
    endtask

    task automatic test_watchdog();
        int cyc;
        set_lane0(1, 8'h3C);
        bus0.req_valid = 4'b0010;
        @(negedge clk);
        checks++; if (bus0.start_tx !== 1'b1 || bus0.grant_id !== 2'd1) begin
            errors++; $display("FAIL wdog_start: got start=%b id=%0d expected 1/1", bus0.start_tx, bus0.grant_id);
        end
        bus0.req_valid = 4'b0000;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus0.busy === 1'b1 && cyc < 200);
        checks++; if (cyc !== WDOG + 1) begin errors++; $display("FAIL wdog_exit_cycle: got %0d expected %0d", cyc, WDOG + 1); end
        checks++; if (bus0.wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_err_set: got %b expected 1", bus0.wdog_err); end
        bus0.clr_err = 1'b1;
        @(negedge clk);
        bus0.clr_err = 1'b0;
        checks++; if (bus0.wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_clear: got %b expected 0", bus0.wdog_err); end

        // Clear raised on the very cycle the watchdog fires: the set must win.
        bus0.req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (bus0.start_tx !== 1'b1 || bus0.grant_id !== 2'd2) begin
            errors++; $display("FAIL wdog2_start: got start=%b id=%0d expected 1/2", bus0.start_tx, bus0.grant_id);
        end
        bus0.req_valid = 4'b0000;
        repeat (WDOG) @(negedge clk);
        checks++; if (bus0.busy !== 1'b1) begin errors++; $display("FAIL wdog_last_cycle_busy: got %b expected 1", bus0.busy); end
        bus0.clr_err = 1'b1;
        @(negedge clk);
        bus0.clr_err = 1'b0;
        checks++; if (bus0.busy !== 1'b0 || bus0.wdog_err !== 1'b1) begin
            errors++; $display("FAIL wdog_set_beats_clear: got busy=%b err=%b expected 0/1", bus0.busy, bus0.wdog_err);
        end
        bus0.clr_err = 1'b1;
        @(negedge clk);
        bus0.clr_err = 1'b0;
        checks++; if (bus0.wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_clear2: got %b expected 0", bus0.wdog_err); end
        model_ptr = 3;
    endtask

    task automatic test_done_final();
        bus0.req_valid = 4'b1000;
        @(negedge clk);
        checks++; if (bus0.start_tx !== 1'b1 || bus0.grant_id !== 2'd3) begin
            errors++; $display("FAIL final_start: got start=%b id=%0d expected 1/3", bus0.start_tx, bus0.grant_id);
        end
        bus0.req_valid = 4'b0000;
        repeat (WDOG) @(negedge clk);
        bus0.done_tx = 1'b1;
        @(negedge clk);
        bus0.done_tx = 1'b0;
        checks++; if (bus0.busy !== 1'b0 || bus0.wdog_err !== 1'b0) begin
            errors++; $display("FAIL final_done_wins: got busy=%b err=%b expected 0/0", bus0.busy, bus0.wdog_err);
        end
        model_ptr = 0;
    endtask

    task automatic test_done_ignored();
        bus0.done_tx = 1'b1;
        repeat (3) @(negedge clk);
        bus0.done_tx = 1'b0;
        checks++; if (bus0.busy !== 1'b0 || bus0.start_tx !== 1'b0 || bus0.wdog_err !== 1'b0) begin
            errors++; $display("FAIL idle_done_ignored: got busy=%b start=%b err=%b expected 0/0/0", bus0.busy, bus0.start_tx, bus0.wdog_err);
        end
    endtask

    task automatic test_gap();
        int cyc;
        int gap_busy;
        int idle_cnt;
        bus1.req_data = 32'h44_33_22_11;
        bus1.req_valid = 4'b0001;
        @(negedge clk);
        checks++; if (bus1.start_tx !== 1'b1 || bus1.data_tx !== 8'h11) begin
            errors++; $display("FAIL gap_first_start: got start=%b data=%h expected 1/11", bus1.start_tx, bus1.data_tx);
        end
        bus1.req_valid = 4'b0100;
        repeat (3) @(negedge clk);
        bus1.done_tx = 1'b1;
        cyc = 0; gap_busy = 0; idle_cnt = 0;
        do begin
            @(negedge clk);
            bus1.done_tx = 1'b0;
            cyc++;
            if (bus1.start_tx !== 1'b1) begin
                if (bus1.busy === 1'b1) gap_busy++;
                else idle_cnt++;
            end
        end while (bus1.start_tx !== 1'b1 && cyc < 40);
        checks++; if (cyc !== GAP + 2) begin errors++; $display("FAIL gap_spacing: got %0d expected %0d", cyc, GAP + 2); end
        checks++; if (gap_busy !== GAP || idle_cnt !== 1) begin
            errors++; $display("FAIL gap_cycles: got gap=%0d idle=%0d expected %0d/1", gap_busy, idle_cnt, GAP);
        end
        checks++; if (bus1.req_ready !== 4'b0100 || bus1.data_tx !== 8'h33) begin
            errors++; $display("FAIL gap_second_grant: got ready=%b data=%h expected 0100/33", bus1.req_ready, bus1.data_tx);
        end
        bus1.req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid();
        bus0.req_data = 32'hD4_C3_B2_A1;
        bus0.req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (bus0.start_tx !== 1'b1 || bus0.grant_id !== 2'd2) begin
            errors++; $display("FAIL mid_start: got start=%b id=%0d expected 1/2", bus0.start_tx, bus0.grant_id);
        end
        bus0.req_valid = 4'b0000;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus0.busy !== 1'b0 || bus0.start_tx !== 1'b0 || bus0.req_ready !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_outputs: got busy=%b start=%b ready=%b expected 0/0/0000", bus0.busy, bus0.start_tx, bus0.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus0.req_valid = 4'b1111;
        @(negedge clk);
        checks++; if (bus0.start_tx !== 1'b1 || bus0.req_ready !== 4'b0001 || bus0.data_tx !== 8'hA1) begin
            errors++; $display("FAIL mid_regrant_from0: got start=%b ready=%b data=%h expected 1/0001/a1", bus0.start_tx, bus0.req_ready, bus0.data_tx);
        end
        bus0.req_valid = 4'b0000;
        @(negedge clk);
        bus0.done_tx = 1'b1;
        @(negedge clk);
        bus0.done_tx = 1'b0;
        model_ptr = 1;
        model_err = 1'b0;
    endtask

    task automatic test_random();
        logic [N-1:0] pend;
        logic [N-1:0] newm;
        logic [7:0]   lane[N];
        logic [3:0]   exp_ready;
        logic [7:0]   exp_data;
        int win;
        int d;
        pend = '0;
        for (int i = 0; i < N; i++) lane[i] = '0;
        for (int f = 0; f < 40; f++) begin
            newm = N'($urandom_range(0, 15)) & ~pend;
            if ((pend | newm) == '0) newm = N'(1) << $urandom_range(0, N - 1);
            for (int i = 0; i < N; i++) begin
                if (newm[i]) begin
                    lane[i] = 8'($urandom_range(0, 255));
                    set_lane0(i, lane[i]);
                end
            end
            pend = pend | newm;
            bus0.req_valid = pend;
            if (model_err && $urandom_range(0, 1) == 1) begin
                bus0.clr_err = 1'b1;
                model_err = 1'b0;
            end
            win = rr_pick(pend, model_ptr);
            exp_q.push_back(lane[win]);
            @(negedge clk);
            bus0.clr_err = 1'b0;
            exp_ready = 4'b0001 << win;
            exp_data = exp_q.pop_front();
            checks++; if (bus0.start_tx !== 1'b1 || bus0.req_ready !== exp_ready) begin
                errors++; $display("FAIL rnd_grant%0d: got start=%b ready=%b expected 1/%b", f, bus0.start_tx, bus0.req_ready, exp_ready);
            end
            checks++; if (bus0.data_tx !== exp_data || bus0.grant_id !== 2'(win)) begin
                errors++; $display("FAIL rnd_data%0d: got data=%h id=%0d expected %h/%0d", f, bus0.data_tx, bus0.grant_id, exp_data, win);
            end
            checks++; if (bus0.wdog_err !== model_err) begin
                errors++; $display("FAIL rnd_err_at_start%0d: got %b expected %b", f, bus0.wdog_err, model_err);
            end
            pend[win] = 1'b0;
            bus0.req_valid = pend;
            model_ptr = (win + 1) % N;
            d = $urandom_range(1, 80);
            if (d <= WDOG) begin
                repeat (d) @(negedge clk);
                bus0.done_tx = 1'b1;
                @(negedge clk);
                bus0.done_tx = 1'b0;
            end else begin
                repeat (WDOG) @(negedge clk);
                checks++; if (bus0.busy !== 1'b1) begin
                    errors++; $display("FAIL rnd_busy_last%0d: got %b expected 1", f, bus0.busy);
                end
                @(negedge clk);
                model_err = 1'b1;
            end
            checks++; if (bus0.busy !== 1'b0 || bus0.wdog_err !== model_err) begin
                errors++; $display("FAIL rnd_end%0d: got busy=%b err=%b expected 0/%b", f, bus0.busy, bus0.wdog_err, model_err);
            end
        end
        bus0.req_valid = '0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        init_inputs();
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_watchdog();
        test_done_final();
        test_done_ignored();
        test_gap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
